// File: rtl/cim_xbar_model.sv
// Behavioural CIM crossbar tile: buffered input vector, 1-bit weight array, bit-sliced MVM with ADC quantisation.
// Optional build macro CIM_ADC_SAT_EN: saturate quantised column outputs instead of wrapping.
module cim_xbar_model #(
   parameter int unsigned xbar_size     = 128,
   parameter int unsigned datatype_size = 4,
   parameter int unsigned adc_shift     = 4,
   parameter int unsigned settle_cycles = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         i_we,
   input  logic [$clog2(xbar_size)-1:0] i_wr_addr,
   input  logic [datatype_size-1:0]     i_wr_data,
   input  logic                         i_exec,
   output logic                         o_busy,
   input  logic [$clog2(xbar_size)-1:0] i_rd_addr,
   output logic [datatype_size-1:0]     o_rd_data,
   input  logic                         i_wgt_we,
   input  logic [$clog2(xbar_size)-1:0] i_wgt_row,
   input  logic [$clog2(xbar_size)-1:0] i_wgt_col,
   input  logic                         i_wgt_bit,
   output logic                         o_drop
);

   localparam int unsigned ROW_W = $clog2(xbar_size);
   localparam int unsigned ACC_W = datatype_size + ROW_W + 1;
   localparam int unsigned SET_W = (settle_cycles > 1) ? $clog2(settle_cycles) : 1;

   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(xbar_size - 1);
   localparam logic [SET_W-1:0] LAST_SET = SET_W'((settle_cycles == 0) ? 0 : settle_cycles - 1);
   localparam logic [ACC_W-1:0] SAT_LIM  = {{(ACC_W-datatype_size){1'b0}}, {datatype_size{1'b1}}};

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACC,
      ST_SETTLE,
      ST_QUANT
   } state_t;

   state_t                   r_state;
   state_t                   w_state_nxt;
   logic [ROW_W-1:0]         r_row;
   logic [SET_W-1:0]         r_settle;
   logic                     r_busy;
   logic                     r_drop;
   logic [datatype_size-1:0] r_rd_data;

   logic [datatype_size-1:0] r_in  [xbar_size];
   logic [xbar_size-1:0]     r_wgt [xbar_size];
   logic [ACC_W-1:0]         r_acc [xbar_size];
   logic [datatype_size-1:0] r_res [xbar_size];

   logic                     w_idle;
   logic [datatype_size-1:0] w_row_in;
   logic [xbar_size-1:0]     w_row_wgt;

   assign w_idle    = (r_state == ST_IDLE);
   assign w_row_in  = r_in[r_row];
   assign w_row_wgt = r_wgt[r_row];

   assign o_busy    = r_busy;
   assign o_drop    = r_drop;
   assign o_rd_data = r_rd_data;

   // ADC model: scale the column sum down, then either clip or keep the low bits.
   function automatic logic [datatype_size-1:0] quantize(input logic [ACC_W-1:0] a);
`ifdef CIM_ADC_SAT_EN
      if ((a >> adc_shift) > SAT_LIM) return '1;
`endif
      return datatype_size'(a >> adc_shift);
   endfunction

   // NOTE: every output of this block gets a default first so no latch is inferred.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:   if (i_exec) w_state_nxt = ST_ACC;
         ST_ACC:    if (r_row == LAST_ROW) w_state_nxt = (settle_cycles == 0) ? ST_QUANT : ST_SETTLE;
         ST_SETTLE: if (r_settle == LAST_SET) w_state_nxt = ST_QUANT;
         ST_QUANT:  w_state_nxt = ST_IDLE;
         default:   w_state_nxt = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_row     <= '0;
         r_settle  <= '0;
         r_busy    <= 1'b0;
         r_drop    <= 1'b0;
         r_rd_data <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_busy    <= (w_state_nxt != ST_IDLE);
         r_drop    <= !w_idle && (i_we || i_wgt_we || i_exec);
         r_row     <= (r_state == ST_ACC) ? r_row + ROW_W'(1) : '0;
         r_settle  <= (r_state == ST_SETTLE) ? r_settle + SET_W'(1) : '0;
         r_rd_data <= r_res[i_rd_addr];
      end
   end

   // NOTE: storage arrays are reset explicitly because a reset must leave the tile fully cleared.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < xbar_size; r++) begin
            r_in[r]  <= '0;
            r_wgt[r] <= '0;
         end
      end else if (w_idle) begin
         if (i_we)     r_in[i_wr_addr]             <= i_wr_data;
         if (i_wgt_we) r_wgt[i_wgt_row][i_wgt_col] <= i_wgt_bit;
      end
   end

   // One input row per cycle is broadcast to every column accumulator.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int c = 0; c < xbar_size; c++) begin
            r_acc[c] <= '0;
            r_res[c] <= '0;
         end
      end else begin
         for (int c = 0; c < xbar_size; c++) begin
            if (r_state == ST_ACC && w_row_wgt[c]) begin
               r_acc[c] <= r_acc[c] + ACC_W'(w_row_in);
            end else if (r_state == ST_QUANT) begin
               r_res[c] <= quantize(r_acc[c]);
               r_acc[c] <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_cim_xbar_model.sv
// Directed bench for cim_xbar_model: two tiles (adc_shift 0 and 4) share stimulus, outputs checked separately.
module tb_cim_xbar_model;

   localparam int XS = 128;
   localparam int DS = 4;
   localparam int RW = 7;

`ifdef CIM_ADC_SAT_EN
   localparam logic [DS-1:0] EXP_SAT4 = 4'd15;
   localparam logic [DS-1:0] EXP_SAT0 = 4'd15;
`else
   localparam logic [DS-1:0] EXP_SAT4 = 4'd8;
   localparam logic [DS-1:0] EXP_SAT0 = 4'd0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          i_we = 1'b0;
   logic [RW-1:0] i_wr_addr = '0;
   logic [DS-1:0] i_wr_data = '0;
   logic          i_exec = 1'b0;
   logic [RW-1:0] i_rd_addr = '0;
   logic          i_wgt_we = 1'b0;
   logic [RW-1:0] i_wgt_row = '0;
   logic [RW-1:0] i_wgt_col = '0;
   logic          i_wgt_bit = 1'b0;

   logic          o_busy0, o_drop0, o_busy4, o_drop4;
   logic [DS-1:0] o_rd0, o_rd4;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   cim_xbar_model #(.xbar_size(XS), .datatype_size(DS), .adc_shift(0), .settle_cycles(2)) dut0 (
      .clk(clk), .rst(rst), .i_we(i_we), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
      .i_exec(i_exec), .o_busy(o_busy0), .i_rd_addr(i_rd_addr), .o_rd_data(o_rd0),
      .i_wgt_we(i_wgt_we), .i_wgt_row(i_wgt_row), .i_wgt_col(i_wgt_col), .i_wgt_bit(i_wgt_bit),
      .o_drop(o_drop0)
   );

   cim_xbar_model #(.xbar_size(XS), .datatype_size(DS), .adc_shift(4), .settle_cycles(2)) dut4 (
      .clk(clk), .rst(rst), .i_we(i_we), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
      .i_exec(i_exec), .o_busy(o_busy4), .i_rd_addr(i_rd_addr), .o_rd_data(o_rd4),
      .i_wgt_we(i_wgt_we), .i_wgt_row(i_wgt_row), .i_wgt_col(i_wgt_col), .i_wgt_bit(i_wgt_bit),
      .o_drop(o_drop4)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_exec();
      i_exec = 1'b1;
      tick();
      i_exec = 1'b0;
   endtask

   task automatic wait_idle(output int cnt);
      cnt = 0;
      while (o_busy0 === 1'b1 && cnt < 1000) begin
         cnt++;
         tick();
      end
      if (cnt >= 1000) begin
         checks++;
         errors++;
         $display("FAIL busy_timeout: o_busy still %b after %0d cycles", o_busy0, cnt);
      end
   endtask

   task automatic read_col(input int col);
      i_rd_addr = RW'(col);
      tick();
   endtask

   task automatic test_reset();
      repeat (2) tick();
      rst = 1'b0;
      tick();
      checks++;
      if (o_busy0 !== 1'b0 || o_busy4 !== 1'b0) begin
         errors++;
         $display("FAIL reset_busy: got %b/%b expected 0/0", o_busy0, o_busy4);
      end
      checks++;
      if (o_drop0 !== 1'b0 || o_drop4 !== 1'b0) begin
         errors++;
         $display("FAIL reset_drop: got %b/%b expected 0/0", o_drop0, o_drop4);
      end
      read_col(77);
      checks++;
      if (o_rd0 !== 4'd0 || o_rd4 !== 4'd0) begin
         errors++;
         $display("FAIL reset_rd: got %0d/%0d expected 0/0", o_rd0, o_rd4);
      end
   endtask

   task automatic test_identity();
      int cnt;
      for (int r = 0; r < XS; r++) begin
         i_we = 1'b1;     i_wr_addr = RW'(r); i_wr_data = DS'(r % 16);
         i_wgt_we = 1'b1; i_wgt_row = RW'(r); i_wgt_col = RW'(r); i_wgt_bit = 1'b1;
         tick();
      end
      i_we = 1'b0;
      i_wgt_we = 1'b0;
      start_exec();
      wait_idle(cnt);
      checks++;
      if (cnt !== 131) begin
         errors++;
         $display("FAIL ident_busy_len: got %0d expected 131", cnt);
      end
      read_col(5);
      checks++;
      if (o_rd0 !== 4'd5) begin
         errors++;
         $display("FAIL ident_col5: got %0d expected 5", o_rd0);
      end
      read_col(20);
      checks++;
      if (o_rd0 !== 4'd4) begin
         errors++;
         $display("FAIL ident_col20: got %0d expected 4", o_rd0);
      end
      read_col(127);
      checks++;
      if (o_rd0 !== 4'd15) begin
         errors++;
         $display("FAIL ident_col127: got %0d expected 15", o_rd0);
      end
   endtask

   task automatic test_busy_drop();
      int cnt;
      start_exec();
      cnt = 0;
      while (o_busy0 === 1'b1 && cnt < 1000) begin
         cnt++;
         if (cnt == 10) begin
            i_we = 1'b1;     i_wr_addr = 7'd3; i_wr_data = 4'd9;
            i_wgt_we = 1'b1; i_wgt_row = 7'd3; i_wgt_col = 7'd3; i_wgt_bit = 1'b0;
            i_exec = 1'b1;
         end
         tick();
         if (cnt == 10) begin
            i_we = 1'b0;
            i_wgt_we = 1'b0;
            i_exec = 1'b0;
            checks++;
            if (o_drop0 !== 1'b1) begin
               errors++;
               $display("FAIL drop_pulse: got %b expected 1", o_drop0);
            end
         end
         if (cnt == 11) begin
            checks++;
            if (o_drop0 !== 1'b0) begin
               errors++;
               $display("FAIL drop_clear: got %b expected 0", o_drop0);
            end
         end
      end
      checks++;
      if (cnt !== 131) begin
         errors++;
         $display("FAIL drop_busy_len: got %0d expected 131", cnt);
      end
      repeat (3) tick();
      checks++;
      if (o_busy0 !== 1'b0) begin
         errors++;
         $display("FAIL drop_no_rerun: busy got %b expected 0", o_busy0);
      end
      read_col(3);
      checks++;
      if (o_rd0 !== 4'd3) begin
         errors++;
         $display("FAIL drop_col3: got %0d expected 3", o_rd0);
      end
   endtask

   task automatic test_read_stability();
      int cnt;
      i_we = 1'b1; i_wr_addr = 7'd5; i_wr_data = 4'd9;
      tick();
      i_we = 1'b0;
      read_col(5);
      checks++;
      if (o_rd0 !== 4'd5) begin
         errors++;
         $display("FAIL stab_pre: got %0d expected 5", o_rd0);
      end
      start_exec();
      cnt = 0;
      while (o_busy0 === 1'b1 && cnt < 1000) begin
         cnt++;
         checks++;
         if (o_rd0 !== 4'd5) begin
            errors++;
            $display("FAIL stab_busy cycle %0d: got %0d expected 5", cnt, o_rd0);
         end
         tick();
      end
      tick();
      checks++;
      if (o_rd0 !== 4'd9) begin
         errors++;
         $display("FAIL stab_post: got %0d expected 9", o_rd0);
      end
   endtask

   task automatic test_simultaneous();
      int cnt;
      i_we = 1'b1; i_wr_addr = 7'd0; i_wr_data = 4'd7; i_exec = 1'b1;
      tick();
      i_we = 1'b0;
      i_exec = 1'b0;
      wait_idle(cnt);
      read_col(0);
      checks++;
      if (o_rd0 !== 4'd7) begin
         errors++;
         $display("FAIL simul_col0: got %0d expected 7", o_rd0);
      end
      read_col(5);
      checks++;
      if (o_rd0 !== 4'd9) begin
         errors++;
         $display("FAIL simul_persist_col5: got %0d expected 9", o_rd0);
      end
   endtask

   task automatic test_saturation();
      int cnt;
      for (int r = 0; r < XS; r++) begin
         for (int c = 0; c < XS; c++) begin
            i_we = (c == 0);  i_wr_addr = RW'(r); i_wr_data = 4'd15;
            i_wgt_we = 1'b1;  i_wgt_row = RW'(r); i_wgt_col = RW'(c); i_wgt_bit = 1'b1;
            tick();
         end
      end
      i_we = 1'b0;
      i_wgt_we = 1'b0;
      start_exec();
      wait_idle(cnt);
      read_col(0);
      checks++;
      if (o_rd4 !== EXP_SAT4) begin
         errors++;
         $display("FAIL sat_shift4_col0: got %0d expected %0d", o_rd4, EXP_SAT4);
      end
      read_col(127);
      checks++;
      if (o_rd4 !== EXP_SAT4) begin
         errors++;
         $display("FAIL sat_shift4_col127: got %0d expected %0d", o_rd4, EXP_SAT4);
      end
      read_col(64);
      checks++;
      if (o_rd0 !== EXP_SAT0) begin
         errors++;
         $display("FAIL sat_shift0_col64: got %0d expected %0d", o_rd0, EXP_SAT0);
      end
   endtask

   task automatic test_reset_mid();
      int cnt;
      int bad;
      start_exec();
      repeat (10) tick();
      rst = 1'b1;
      #1;
      checks++;
      if (o_busy0 !== 1'b0 || o_busy4 !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_busy: got %b/%b expected 0/0", o_busy0, o_busy4);
      end
      checks++;
      if (o_rd4 !== 4'd0) begin
         errors++;
         $display("FAIL rstmid_rd_immediate: got %0d expected 0", o_rd4);
      end
      #2;
      rst = 1'b0;
      tick();
      bad = 0;
      for (int c = 0; c < XS; c++) begin
         read_col(c);
         if (o_rd0 !== 4'd0 || o_rd4 !== 4'd0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL rstmid_results: %0d columns nonzero, expected 0", bad);
      end
      i_we = 1'b1; i_wr_addr = 7'd0; i_wr_data = 4'd15;
      tick();
      i_we = 1'b0;
      start_exec();
      wait_idle(cnt);
      checks++;
      if (cnt !== 131) begin
         errors++;
         $display("FAIL rstmid_busy_len: got %0d expected 131", cnt);
      end
      read_col(0);
      checks++;
      if (o_rd0 !== 4'd0) begin
         errors++;
         $display("FAIL rstmid_wgt_cleared: got %0d expected 0", o_rd0);
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_identity();
      test_busy_drop();
      test_read_stability();
      test_simultaneous();
      test_saturation();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
